// File: rtl/dsp_voice_mixer_sched.sv
// Per-frame voice scheduler and stereo mixer: slot triggers, RAM voice select,
// shared-multiplier MAC per channel, main volume with saturation, one DAC sample per frame.
module dsp_voice_mixer_sched #(
  parameter int N_VOICES          = 8,
  parameter int SAMPLE_WIDTH      = 16,
  parameter int VOL_WIDTH         = 8,
  parameter int CLOCKS_PER_SAMPLE = 64,
  parameter int SLOT_CYCLES       = 4,
  parameter int FIRST_SLOT        = 2,
  parameter int MIX_START         = 40,
  localparam int SEL_W            = (N_VOICES > 1) ? $clog2(N_VOICES) : 1,
  localparam int STEP_W           = $clog2(CLOCKS_PER_SAMPLE)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [N_VOICES-1:0]                voice_enable,
  input  logic                               mute,
  input  logic [N_VOICES*SAMPLE_WIDTH-1:0]   voice_sample,
  input  logic [N_VOICES*VOL_WIDTH-1:0]      vol_l,
  input  logic [N_VOICES*VOL_WIDTH-1:0]      vol_r,
  input  logic signed [VOL_WIDTH-1:0]        mvol_l,
  input  logic signed [VOL_WIDTH-1:0]        mvol_r,
  output logic [N_VOICES-1:0]                voice_trigger,
  output logic [SEL_W-1:0]                   voice_sel,
  output logic [STEP_W-1:0]                  frame_step,
  output logic signed [SAMPLE_WIDTH-1:0]     dac_out_l,
  output logic signed [SAMPLE_WIDTH-1:0]     dac_out_r,
  output logic                               sample_valid
);

  localparam int PROD_W = SAMPLE_WIDTH + VOL_WIDTH;
  localparam int ACC_W  = SAMPLE_WIDTH + VOL_WIDTH + $clog2(N_VOICES);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  if (N_VOICES < 1 || N_VOICES > 16 ||
      FIRST_SLOT + N_VOICES*SLOT_CYCLES > MIX_START ||
      MIX_START + N_VOICES >= CLOCKS_PER_SAMPLE - 1) begin : g_bad_cfg
    $error("dsp_voice_mixer_sched: illegal schedule parameters");
  end

  function automatic logic signed [SAMPLE_WIDTH-1:0] sat_sw(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[SAMPLE_WIDTH-1:0];
    else                  return x[SAMPLE_WIDTH-1:0];
  endfunction

  logic [STEP_W-1:0]              step_p0;
  logic [N_VOICES-1:0]            trig_q;
  logic [SEL_W-1:0]               sel_q;
  logic                           valid_q;
  logic signed [ACC_W-1:0]        acc_l_p1, acc_r_p1;
  logic signed [SAMPLE_WIDTH-1:0] dac_l_p2, dac_r_p2;

  logic [N_VOICES-1:0]            trig_d;
  logic [SEL_W-1:0]               sel_d;
  logic signed [SAMPLE_WIDTH-1:0] mac_smp;
  logic signed [VOL_WIDTH-1:0]    mac_vl, mac_vr;
  int                             step_i;

  // Slot decode and MAC operand select; operands stay zero outside a voice's MAC step
  // or when that voice is masked, so the accumulator adds nothing.
  always_comb begin
    step_i  = int'(step_p0);
    trig_d  = '0;
    sel_d   = sel_q;
    mac_smp = '0;
    mac_vl  = '0;
    mac_vr  = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      if (step_i == FIRST_SLOT + v*SLOT_CYCLES) begin
        trig_d[v] = voice_enable[v];
        sel_d     = SEL_W'(v);
      end
      if (step_i == MIX_START + v && voice_enable[v]) begin
        mac_smp = voice_sample[v*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        mac_vl  = vol_l[v*VOL_WIDTH +: VOL_WIDTH];
        mac_vr  = vol_r[v*VOL_WIDTH +: VOL_WIDTH];
      end
    end
  end

  logic signed [PROD_W-1:0]       prod_l, prod_r, fin_l, fin_r;
  logic signed [SAMPLE_WIDTH-1:0] m_l, m_r, o_l, o_r;

  assign prod_l = PROD_W'(mac_smp) * PROD_W'(mac_vl);
  assign prod_r = PROD_W'(mac_smp) * PROD_W'(mac_vr);

  // Finalise: mix scaled to sample range, then main volume, each saturated.
  assign m_l   = sat_sw(acc_l_p1 >>> 7);
  assign m_r   = sat_sw(acc_r_p1 >>> 7);
  assign fin_l = PROD_W'(m_l) * PROD_W'(mvol_l);
  assign fin_r = PROD_W'(m_r) * PROD_W'(mvol_r);
  assign o_l   = sat_sw(ACC_W'(fin_l >>> 7));
  assign o_r   = sat_sw(ACC_W'(fin_r >>> 7));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_p0  <= '0;
      trig_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      acc_l_p1 <= '0;
      acc_r_p1 <= '0;
      dac_l_p2 <= '0;
      dac_r_p2 <= '0;
    end else if (!enable) begin
      trig_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      step_p0 <= (step_i == CLOCKS_PER_SAMPLE-1) ? '0 : step_p0 + 1'b1;
      trig_q  <= trig_d;
      sel_q   <= sel_d;
      if (step_i == MIX_START-1) begin
        acc_l_p1 <= '0;
        acc_r_p1 <= '0;
      end else begin
        acc_l_p1 <= acc_l_p1 + ACC_W'(prod_l);
        acc_r_p1 <= acc_r_p1 + ACC_W'(prod_r);
      end
      valid_q <= (step_i == CLOCKS_PER_SAMPLE-1);
      if (step_i == CLOCKS_PER_SAMPLE-1) begin
        dac_l_p2 <= mute ? '0 : o_l;
        dac_r_p2 <= mute ? '0 : o_r;
      end
    end
  end

  assign voice_trigger = trig_q;
  assign voice_sel     = sel_q;
  assign frame_step    = step_p0;
  assign dac_out_l     = dac_l_p2;
  assign dac_out_r     = dac_r_p2;
  assign sample_valid  = valid_q;

endmodule

// File: tb/tb_dsp_voice_mixer_sched.sv
// Directed bench for dsp_voice_mixer_sched with default parameters.
module tb_dsp_voice_mixer_sched;
  localparam int NV = 8, SW = 16, VW = 8, CPS = 64;

  logic clock = 1'b0;
  logic reset, enable, mute;
  logic [NV-1:0]      voice_enable;
  logic [NV*SW-1:0]   voice_sample;
  logic [NV*VW-1:0]   vol_l, vol_r;
  logic signed [VW-1:0] mvol_l, mvol_r;
  logic [NV-1:0]      voice_trigger;
  logic [2:0]         voice_sel;
  logic [5:0]         frame_step;
  logic signed [SW-1:0] dac_out_l, dac_out_r;
  logic               sample_valid;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dsp_voice_mixer_sched dut (
    .clock(clock), .reset(reset), .enable(enable), .voice_enable(voice_enable),
    .mute(mute), .voice_sample(voice_sample), .vol_l(vol_l), .vol_r(vol_r),
    .mvol_l(mvol_l), .mvol_r(mvol_r), .voice_trigger(voice_trigger),
    .voice_sel(voice_sel), .frame_step(frame_step), .dac_out_l(dac_out_l),
    .dac_out_r(dac_out_r), .sample_valid(sample_valid)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] s0, input logic [15:0] s_rest,
                     input logic [7:0] vl0, input logic [7:0] vr0, input logic [7:0] v_rest,
                     input logic [7:0] ml, input logic [7:0] mr);
    for (int v = 0; v < NV; v++) begin
      voice_sample[v*SW +: SW] = (v == 0) ? s0 : s_rest;
      vol_l[v*VW +: VW]        = (v == 0) ? vl0 : v_rest;
      vol_r[v*VW +: VW]        = (v == 0) ? vr0 : v_rest;
    end
    mvol_l = ml;
    mvol_r = mr;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (n < max) begin
      tick();
      n++;
      if (sample_valid) break;
    end
  endtask

  task automatic test_reset();
    checks++; if (frame_step !== 6'd0)    begin errors++; $display("FAIL rst_step got %0d exp 0", frame_step); end
    checks++; if (voice_trigger !== 8'h00) begin errors++; $display("FAIL rst_trig got %h exp 00", voice_trigger); end
    checks++; if (voice_sel !== 3'd0)     begin errors++; $display("FAIL rst_sel got %0d exp 0", voice_sel); end
    checks++; if (dac_out_l !== 16'sd0)   begin errors++; $display("FAIL rst_dac_l got %0d exp 0", dac_out_l); end
    checks++; if (dac_out_r !== 16'sd0)   begin errors++; $display("FAIL rst_dac_r got %0d exp 0", dac_out_r); end
    checks++; if (sample_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %b exp 0", sample_valid); end
  endtask

  task automatic test_timing();
    logic [NV-1:0] exp_trig;
    logic [2:0]    exp_sel;
    int n;
    voice_enable = 8'hFF;
    cfg(16'h1234, 16'h0100, 8'h10, 8'h20, 8'h05, 8'h7F, 8'h7F);
    enable = 1'b1;
    restart();
    exp_sel = 3'd0;
    for (int cyc = 1; cyc <= CPS; cyc++) begin
      tick();
      // outputs registered on the edge at step 2+4v are visible one step later
      exp_trig = '0;
      for (int v = 0; v < NV; v++)
        if (cyc == 2 + 4*v + 1) begin exp_trig[v] = 1'b1; exp_sel = 3'(v); end
      checks++; if (frame_step !== 6'(cyc % CPS)) begin errors++; $display("FAIL tim_step cyc=%0d got %0d exp %0d", cyc, frame_step, cyc % CPS); end
      checks++; if (voice_trigger !== exp_trig) begin errors++; $display("FAIL tim_trig cyc=%0d got %h exp %h", cyc, voice_trigger, exp_trig); end
      checks++; if (voice_sel !== exp_sel) begin errors++; $display("FAIL tim_sel cyc=%0d got %0d exp %0d", cyc, voice_sel, exp_sel); end
      checks++; if (sample_valid !== (cyc == CPS)) begin errors++; $display("FAIL tim_valid cyc=%0d got %b exp %b", cyc, sample_valid, cyc == CPS); end
    end
    wait_valid(200, n);
    checks++; if (n != CPS) begin errors++; $display("FAIL tim_period got %0d exp %0d", n, CPS); end
  endtask

  task automatic run_frame(input string name, input logic signed [15:0] el, input logic signed [15:0] er);
    int n;
    restart();
    wait_valid(200, n);
    checks++; if (n != CPS) begin errors++; $display("FAIL %s_lat got %0d exp %0d", name, n, CPS); end
    checks++; if (dac_out_l !== el) begin errors++; $display("FAIL %s_l got %0d exp %0d", name, dac_out_l, el); end
    checks++; if (dac_out_r !== er) begin errors++; $display("FAIL %s_r got %0d exp %0d", name, dac_out_r, er); end
  endtask

  task automatic test_single_voice();
    voice_enable = 8'hFF;
    cfg(16'h4000, 16'h0000, 8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F);
    run_frame("single", 16'sd16129, 16'sd16129);
  endtask

  task automatic test_saturation();
    cfg(16'h7FFF, 16'h7FFF, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    run_frame("sat_pos", 16'sd32511, 16'sd32511);
    cfg(16'h8000, 16'h8000, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    run_frame("sat_neg", -16'sd32512, -16'sd32512);
  endtask

  task automatic test_neg_volume();
    cfg(16'h7FFF, 16'h0000, 8'h80, 8'h00, 8'h00, 8'h80, 8'h7F);
    run_frame("negvol", 16'sd32767, 16'sd0);
  endtask

  task automatic test_mask_mute();
    bit seen0;
    int n;
    cfg(16'h4000, 16'h0000, 8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F);
    voice_enable = 8'hFE;
    restart();
    seen0 = 1'b0;
    for (int cyc = 1; cyc <= CPS; cyc++) begin
      tick();
      if (voice_trigger[0]) seen0 = 1'b1;
    end
    checks++; if (seen0 !== 1'b0) begin errors++; $display("FAIL mask_trig0 got %b exp 0", seen0); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL mask_valid got %b exp 1", sample_valid); end
    checks++; if (dac_out_l !== 16'sd0) begin errors++; $display("FAIL mask_l got %0d exp 0", dac_out_l); end
    checks++; if (dac_out_r !== 16'sd0) begin errors++; $display("FAIL mask_r got %0d exp 0", dac_out_r); end
    voice_enable = 8'hFF;
    mute = 1'b1;
    wait_valid(200, n);
    checks++; if (n != CPS) begin errors++; $display("FAIL mute_valid got %0d exp %0d", n, CPS); end
    checks++; if (dac_out_l !== 16'sd0) begin errors++; $display("FAIL mute_l got %0d exp 0", dac_out_l); end
    checks++; if (dac_out_r !== 16'sd0) begin errors++; $display("FAIL mute_r got %0d exp 0", dac_out_r); end
    mute = 1'b0;
    wait_valid(200, n);
    checks++; if (dac_out_l !== 16'sd16129) begin errors++; $display("FAIL unmute_l got %0d exp 16129", dac_out_l); end
  endtask

  task automatic test_enable_gap();
    int n, m;
    voice_enable = 8'hFF;
    cfg(16'h4000, 16'h0000, 8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F);
    restart();
    n = 0;
    while (frame_step != 6'd20 && n < 100) begin tick(); n++; end
    enable = 1'b0;
    repeat (10) begin
      tick();
      n++;
      checks++; if (sample_valid !== 1'b0 || voice_trigger !== 8'h00) begin errors++; $display("FAIL gap_pulse got v=%b t=%h exp 0", sample_valid, voice_trigger); end
    end
    checks++; if (frame_step !== 6'd20) begin errors++; $display("FAIL gap_hold got %0d exp 20", frame_step); end
    enable = 1'b1;
    wait_valid(200, m);
    checks++; if (n + m != CPS + 10) begin errors++; $display("FAIL gap_delay got %0d exp %0d", n + m, CPS + 10); end
    checks++; if (dac_out_l !== 16'sd16129) begin errors++; $display("FAIL gap_l got %0d exp 16129", dac_out_l); end
    checks++; if (dac_out_r !== 16'sd16129) begin errors++; $display("FAIL gap_r got %0d exp 16129", dac_out_r); end
  endtask

  task automatic test_reset_mid();
    int n;
    voice_enable = 8'hFF;
    cfg(16'h4000, 16'h0000, 8'h7F, 8'h7F, 8'h00, 8'h7F, 8'h7F);
    run_frame("pre_rst", 16'sd16129, 16'sd16129);
    n = 0;
    while (frame_step != 6'd45 && n < 100) begin tick(); n++; end
    reset = 1'b1;
    #1;
    checks++; if (dac_out_l !== 16'sd0 || dac_out_r !== 16'sd0) begin errors++; $display("FAIL midrst_dac got %0d/%0d exp 0/0", dac_out_l, dac_out_r); end
    checks++; if (frame_step !== 6'd0) begin errors++; $display("FAIL midrst_step got %0d exp 0", frame_step); end
    tick();
    reset = 1'b0;
    wait_valid(200, n);
    checks++; if (n != CPS) begin errors++; $display("FAIL midrst_lat got %0d exp %0d", n, CPS); end
    checks++; if (dac_out_l !== 16'sd16129) begin errors++; $display("FAIL midrst_l got %0d exp 16129", dac_out_l); end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    mute = 1'b0;
    voice_enable = '0;
    voice_sample = '0;
    vol_l = '0;
    vol_r = '0;
    mvol_l = '0;
    mvol_r = '0;
    #2;
    test_reset();
    test_timing();
    test_single_voice();
    test_saturation();
    test_neg_volume();
    test_mask_mute();
    test_enable_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
